// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU opcodes and
// the stage FSM states.
package cpu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int SHAMT_W    = 6;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mul_shift_add_64.sv
// Iterative 64x64 -> low-64 unsigned multiplier, one shift-add step per enabled
// edge; done flags the 64th step so the caller can latch product on that edge.
module mul_shift_add_64
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step_en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [SHAMT_W-1:0]    count_q;

  // product is the accumulator after the current step, so it is final
  // exactly when done is high.
  assign product = acc_q + (b_q[0] ? a_q : '0);
  assign done    = step_en && (count_q == SHAMT_W'(DATA_WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      a_q     <= a;
      b_q     <= b;
      acc_q   <= '0;
      count_q <= '0;
    end else if (step_en) begin
      acc_q   <= product;
      a_q     <= a_q << 1;
      b_q     <= b_q >> 1;
      count_q <= count_q + SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/execute_unit_64_bit.sv
// Execute stage: single-cycle ALU plus iterative multiply behind a
// valid/ready handshake, with registered result and register-file write port.
module execute_unit_64_bit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [4:0]            rd,
  input  logic                  reg_write_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic [4:0]            write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  register_write
);

  import cpu_pkg::*;

  state_e                state_q;
  logic                  reg_write_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_step;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  assign shamt     = operand_b[SHAMT_W-1:0];
  assign in_ready  = E && (state_q == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_op == OP_MUL);
  assign mul_step  = E && (state_q == MUL_BUSY);

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch; unused opcodes (including MUL here) fall through to 0.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_AND:  alu_result = operand_a & operand_b;
      OP_OR:   alu_result = operand_a | operand_b;
      OP_XOR:  alu_result = operand_a ^ operand_b;
      OP_SLL:  alu_result = operand_a << shamt;
      OP_SRL:  alu_result = operand_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(operand_a) >>> shamt);
      OP_SLT:  alu_result[0] = $signed(operand_a) < $signed(operand_b);
      OP_SLTU: alu_result[0] = operand_a < operand_b;
      default: alu_result = '0;
    endcase
  end

  mul_shift_add_64 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step_en (mul_step),
    .a       (operand_a),
    .b       (operand_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Accepting is only possible when the held result is absent or being
  // consumed, so overwriting write_register at accept never loses a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      out_valid      <= 1'b0;
      result         <= '0;
      write_register <= '0;
      reg_write_q    <= 1'b0;
    end else if (E) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_register <= rd;
            reg_write_q    <= reg_write_in;
            if (alu_op == OP_MUL) begin
              state_q   <= MUL_BUSY;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_result;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            result    <= mul_product;
            out_valid <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign zero           = (result == '0);
  assign write_data     = result;
  assign register_write = out_valid && out_ready && E && reg_write_q &&
                          (write_register != 5'd0);

endmodule

// File: doc/execute_unit_64_bit.md
EXECUTE_UNIT_64_BIT -- requirements
Module: execute_unit_64_bit

Interface
REQ-001 Parameter: DATA_WIDTH, 64, operand/result width; all requirements below assume 64.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: E  input  1  stage enable; low freezes all internal state and outputs.
REQ-005 Port: in_valid  input  1  operation presented.
REQ-006 Port: in_ready  output  1  stage can accept an operation this cycle.
REQ-007 Port: alu_op  input  4  operation code (package encoding).
REQ-008 Port: operand_a  input  64  first operand, the register-file read_data1 value.
REQ-009 Port: operand_b  input  64  second operand, the register-file read_data2 value.
REQ-010 Port: rd  input  5  destination register index.
REQ-011 Port: reg_write_in  input  1  operation writes rd.
REQ-012 Port: out_valid  output  1  result held and valid.
REQ-013 Port: out_ready  input  1  downstream consumes the result.
REQ-014 Port: result  output  64  registered result.
REQ-015 Port: zero  output  1  result == 0.
REQ-016 Port: write_register  output  5  register-file write index.
REQ-017 Port: write_data  output  64  register-file write data; equals result.
REQ-018 Port: register_write  output  1  register-file write strobe.

Function
REQ-019 Ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10; codes 11-15 yield result 0.
REQ-020 Arithmetic: modulo 2^64; shift amount is operand_b[5:0]; SLT is signed, SLTU unsigned, both produce 64'd1 or 64'd0; MUL yields the low 64 bits of the unsigned product.
REQ-021 FSM states: IDLE and MUL_BUSY; only IDLE accepts operations.
REQ-022 in_ready = E && state==IDLE && (!out_valid || out_ready), purely combinational.
REQ-023 Accept occurs on a rising edge with in_valid && in_ready; all inputs are captured at that edge.
REQ-024 Single-cycle ops: result, rd, and reg_write are registered at the accept edge; out_valid is 1 after that edge (latency 1).
REQ-025 MUL: on the accept edge, go to MUL_BUSY, load operands, and clear a 6-bit counter; one shift-add step runs per enabled edge.
REQ-026 MUL: on the 64th step edge, load the product, set out_valid, and return to IDLE; out_valid is visible 64 enabled edges after accept.
REQ-027 While out_valid && !out_ready: result, zero, write_register, and out_valid are held stable.
REQ-028 A consume and a new accept on the same edge are legal; the new result replaces the old one with no bubble.
REQ-029 Consume without accept clears out_valid on that edge.
REQ-030 register_write = out_valid && out_ready && E && reg_write_in_q && (write_register != 0); writes to x0 are suppressed.
REQ-031 While E=0: no state, counter, or output-register change, and in_ready=0; register_write is 0.
REQ-032 in_valid while in MUL_BUSY is ignored; upstream holds the operation.

Reset
REQ-033 When rst is asserted, the block enters IDLE immediately: out_valid=0, result=0, zero=1, write_register=0, register_write=0, counter=0.
REQ-034 Reset during MUL_BUSY aborts the multiply; no out_valid is produced for the aborted operation.
REQ-035 After deassertion, in_ready follows REQ-022 (high when E=1).

Structure
REQ-036 Package cpu_pkg holds the alu_op encodings, the FSM state enum, and DATA_WIDTH.
REQ-037 Sub-module mul_shift_add_64 holds the iterative multiplier: start, step-enable, done, 64-bit product.
REQ-038 The ALU combinational logic and the output/handshake registers live in execute_unit_64_bit.

Verification
REQ-039 ADD, a=5, b=7, rd=3, reg_write_in=1, out_ready=1 -> next cycle result=12, zero=0, register_write=1, write_register=3.
REQ-040 SRA, a=64'h8000_0000_0000_0000, b=4 -> result=64'hF800_0000_0000_0000; SLT with a=-1, b=1 -> 1; SLTU with the same operands -> 0.
REQ-041 MUL, a=3, b=64'hFFFF_FFFF_FFFF_FFFF -> in_ready=0 for 64 cycles, then result=64'hFFFF_FFFF_FFFF_FFFD; in_valid during busy is not accepted.
REQ-042 out_ready=0 for 5 cycles after SUB 10-10 -> result=0 and zero=1 held stable, no register_write; out_ready=1 with a new ADD on the same edge -> back-to-back results with no bubble.
REQ-043 rst pulsed mid-MUL at cycle 20 -> out_valid=0 immediately, IDLE, no stray result; E=0 for 3 cycles mid-MUL -> completion delayed by exactly 3 cycles; rd=0 with reg_write_in=1 -> register_write stays 0.
